multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode width (>=6; bits above [5:0] must be zero for a legal opcode).
REQ-002 SHALL have parameter ALU_W, default 4, ALU_control width (>=4; upper bits zero-filled).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, max wait cycles in a handshake state (used only with REQ-030).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 if_req  out  1  instruction fetch request.
REQ-007 if_ack  in  1  fetch done; opcode valid this cycle.
REQ-008 opcode  in  OPCODE_W  opcode of fetched instruction.
REQ-009 mem_req  out  1  data memory request; mem_we  out  1  store when 1.
REQ-010 mem_ack  in  1  data memory access done.
REQ-011 reg_write  out  1  register file write strobe (one cycle).
REQ-012 pc_write  out  1  PC update strobe (one cycle).
REQ-013 branch  out  1; immediate  out  2; mem_inst  out  2; alu_control  out  ALU_W: decoded fields of current instruction.
REQ-014 illegal  out  1  sticky trap flag; state  out  3  current FSM state.

Function
REQ-015 Decode (6-bit code): ALU 0001 for 000000,000001,000010(load),000011(store),100100,000101,000110; 1001 for 100111,001000,001001; 0011 for 101010,001011,001100; 0100 for 101101,001110,001111; 0101 for 110000,010001,010010; 0110 for 010011; 0000 for 010100,010101 (branch).
REQ-016 immediate: 11 for 000000,000101,001000,001011,001110,010001; 10 for 000001,000110,001001,001100,001111,010010; 01 for load, store, branches; else 00.
REQ-017 mem_inst 10 for load, 01 for store, else 00; branch=1 for 010100/010101 only.
REQ-018 Opcode not listed in REQ-015, or nonzero above bit 5, SHALL be illegal.
REQ-019 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6/7 unreachable, SHALL go to TRAP.
REQ-020 FETCH: if_req=1; on if_ack capture opcode, go DECODE; else stay.
REQ-021 DECODE: register decoded fields (held stable until next FETCH exit); illegal -> TRAP, else EXEC.
REQ-022 EXEC: load/store -> MEM; branch -> FETCH with pc_write=1 in EXEC; all others -> WB.
REQ-023 MEM: mem_req=1, mem_we=1 for store; on mem_ack: load -> WB, store -> FETCH with pc_write=1 that cycle.
REQ-024 WB: reg_write=1, pc_write=1 for one cycle; -> FETCH.
REQ-025 reg_write SHALL never assert for store, branch or illegal opcodes.
REQ-026 TRAP: illegal=1, all request/strobe outputs 0; exit only by reset.
REQ-027 Minimum latency, if_ack in first FETCH cycle: ALU op 4 cycles, branch 3, store 4, load 5 (mem_ack first MEM cycle).
REQ-028 Acks arriving outside their wait state SHALL be ignored; if_req and mem_req never both 1.

Reset
REQ-029 rst_n=0 at a clock edge: state=FETCH, if_req=1, mem_req=0, mem_we=0, reg_write=0, pc_write=0, illegal=0, branch=0, immediate=00, mem_inst=00, alu_control=0, timeout counter=0; applies mid-handshake, abandoning the access.

Configuration
REQ-030 Macro MCU_TIMEOUT_EN defined: counter counts consecutive cycles in FETCH or MEM without ack, clears on state change; after TIMEOUT_CYC waiting cycles -> TRAP, illegal=1.
REQ-031 MCU_TIMEOUT_EN undefined: no counter; FETCH/MEM wait indefinitely; TIMEOUT_CYC unused.

Verification
REQ-032 Reset, opcode 000000 with immediate if_ack -> states 0,1,2,4,0; alu_control=0001, immediate=11, reg_write=1 only in WB.
REQ-033 Load 000010, mem_ack after 3 MEM cycles -> mem_req high 3 cycles, mem_we=0, mem_inst=10, WB reg_write=1, total 7 cycles.
REQ-034 Store 000011 -> mem_we=1, mem_inst=01, reg_write never 1, pc_write=1 on mem_ack cycle; branch 010100 -> alu_control=0000, immediate=01, pc_write in EXEC.
REQ-035 Opcode 111111 -> TRAP, illegal=1 held 20 cycles despite acks; rst_n=0 -> FETCH, illegal=0.
REQ-036 MCU_TIMEOUT_EN, TIMEOUT_CYC=8, mem_ack never -> TRAP after 8 MEM cycles; without macro stays in MEM 100 cycles.
REQ-037 rst_n=0 during MEM with mem_ack same cycle -> FETCH next cycle, mem_req=0, no reg_write.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Handshake and decoded-field bundle between the multicycle control unit and its datapath/memories.
// The control unit uses the master modport; the environment uses the slave modport.
interface multicycle_control_unit_if #(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned ALU_W    = 4
);
   logic                if_req;
   logic                if_ack;
   logic [OPCODE_W-1:0] opcode;
   logic                mem_req;
   logic                mem_we;
   logic                mem_ack;
   logic                reg_write;
   logic                pc_write;
   logic                branch;
   logic [1:0]          immediate;
   logic [1:0]          mem_inst;
   logic [ALU_W-1:0]    alu_control;
   logic                illegal;
   logic [2:0]          state;

   modport master (
      output if_req,
      input  if_ack,
      input  opcode,
      output mem_req,
      output mem_we,
      input  mem_ack,
      output reg_write,
      output pc_write,
      output branch,
      output immediate,
      output mem_inst,
      output alu_control,
      output illegal,
      output state
   );

   modport slave (
      input  if_req,
      output if_ack,
      output opcode,
      input  mem_req,
      input  mem_we,
      output mem_ack,
      input  reg_write,
      input  pc_write,
      input  branch,
      input  immediate,
      input  mem_inst,
      input  alu_control,
      input  illegal,
      input  state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with a sticky illegal-opcode trap.
// Define MCU_TIMEOUT_EN to trap after TIMEOUT_CYC consecutive unacknowledged FETCH/MEM cycles.
module multicycle_control_unit #(
   parameter int unsigned OPCODE_W    = 6,
   parameter int unsigned ALU_W       = 4,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input logic                       clk,
   input logic                       rst_n,
   multicycle_control_unit_if.master bus
);

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] TRAP   = 3'd5;

   localparam logic [1:0] MEM_STORE = 2'b01;
   localparam logic [1:0] MEM_LOAD  = 2'b10;

   logic [2:0] state_q, state_d;
   logic [3:0] alu_q, alu_d;
   logic [1:0] imm_q, imm_d;
   logic [1:0] mem_inst_q, mem_inst_d;
   logic       branch_q, branch_d;
   logic       ill_q, ill_d;

   logic [5:0] op6;
   logic       hi_nz;
   logic [3:0] dec_alu;
   logic [1:0] dec_imm;
   logic [1:0] dec_mem;
   logic       dec_br;
   logic       dec_ill;
   logic       timeout;

   assign op6   = bus.opcode[5:0];
   assign hi_nz = |(bus.opcode >> 6);

   always_comb begin
      dec_alu = 4'b0000;
      dec_imm = 2'b00;
      dec_mem = 2'b00;
      dec_br  = 1'b0;
      dec_ill = 1'b0;
      case (op6)
         6'b000000, 6'b000101: begin dec_alu = 4'b0001; dec_imm = 2'b11; end
         6'b000001, 6'b000110: begin dec_alu = 4'b0001; dec_imm = 2'b10; end
         6'b000010:            begin dec_alu = 4'b0001; dec_imm = 2'b01; dec_mem = MEM_LOAD; end
         6'b000011:            begin dec_alu = 4'b0001; dec_imm = 2'b01; dec_mem = MEM_STORE; end
         6'b100100:            dec_alu = 4'b0001;
         6'b100111:            dec_alu = 4'b1001;
         6'b001000:            begin dec_alu = 4'b1001; dec_imm = 2'b11; end
         6'b001001:            begin dec_alu = 4'b1001; dec_imm = 2'b10; end
         6'b101010:            dec_alu = 4'b0011;
         6'b001011:            begin dec_alu = 4'b0011; dec_imm = 2'b11; end
         6'b001100:            begin dec_alu = 4'b0011; dec_imm = 2'b10; end
         6'b101101:            dec_alu = 4'b0100;
         6'b001110:            begin dec_alu = 4'b0100; dec_imm = 2'b11; end
         6'b001111:            begin dec_alu = 4'b0100; dec_imm = 2'b10; end
         6'b110000:            dec_alu = 4'b0101;
         6'b010001:            begin dec_alu = 4'b0101; dec_imm = 2'b11; end
         6'b010010:            begin dec_alu = 4'b0101; dec_imm = 2'b10; end
         6'b010011:            dec_alu = 4'b0110;
         6'b010100, 6'b010101: begin dec_imm = 2'b01; dec_br = 1'b1; end
         default:              dec_ill = 1'b1;
      endcase
      // Illegal opcodes carry no decoded fields so nothing downstream acts on them.
      if (hi_nz || dec_ill) begin
         dec_ill = 1'b1;
         dec_alu = 4'b0000;
         dec_imm = 2'b00;
         dec_mem = 2'b00;
         dec_br  = 1'b0;
      end
   end

`ifdef MCU_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             waiting;

   assign waiting = ((state_q == FETCH) && !bus.if_ack) || ((state_q == MEM) && !bus.mem_ack);
   assign timeout = waiting && (32'(cnt_q) == TIMEOUT_CYC - 1);

   // Counts unacknowledged wait cycles; any state change clears it.
   always_comb begin
      cnt_d = '0;
      if (waiting && !timeout) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      alu_d      = alu_q;
      imm_d      = imm_q;
      mem_inst_d = mem_inst_q;
      branch_d   = branch_q;
      ill_d      = ill_q;
      case (state_q)
         FETCH: begin
            if (bus.if_ack) begin
               state_d    = DECODE;
               alu_d      = dec_alu;
               imm_d      = dec_imm;
               mem_inst_d = dec_mem;
               branch_d   = dec_br;
               ill_d      = dec_ill;
            end else if (timeout) begin
               state_d = TRAP;
            end
         end
         DECODE: state_d = ill_q ? TRAP : EXEC;
         EXEC: begin
            if (mem_inst_q != 2'b00) begin
               state_d = MEM;
            end else if (branch_q) begin
               state_d = FETCH;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            if (bus.mem_ack) begin
               state_d = (mem_inst_q == MEM_STORE) ? FETCH : WB;
            end else if (timeout) begin
               state_d = TRAP;
            end
         end
         WB:      state_d = FETCH;
         TRAP:    state_d = TRAP;
         default: state_d = TRAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         alu_q      <= 4'b0000;
         imm_q      <= 2'b00;
         mem_inst_q <= 2'b00;
         branch_q   <= 1'b0;
         ill_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_q      <= alu_d;
         imm_q      <= imm_d;
         mem_inst_q <= mem_inst_d;
         branch_q   <= branch_d;
         ill_q      <= ill_d;
      end
   end

   always_comb begin
      bus.if_req      = (state_q == FETCH);
      bus.mem_req     = (state_q == MEM);
      bus.mem_we      = (state_q == MEM) && (mem_inst_q == MEM_STORE);
      // Only ALU ops and loads ever reach WB, so stores/branches never write the register file.
      bus.reg_write   = (state_q == WB);
      bus.pc_write    = (state_q == WB)
                     || ((state_q == EXEC) && branch_q)
                     || ((state_q == MEM) && (mem_inst_q == MEM_STORE) && bus.mem_ack);
      bus.illegal     = (state_q == TRAP);
      bus.branch      = branch_q;
      bus.immediate   = imm_q;
      bus.mem_inst    = mem_inst_q;
      bus.alu_control = ALU_W'(alu_q);
      bus.state       = state_q;
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: instruction-route reference model,
// directed literal scenarios, then randomized traffic.
module tb_multicycle_control_unit;
   localparam int unsigned OW = 8;
   localparam int unsigned AW = 5;
   localparam int unsigned TO = 8;

   typedef struct packed {
      logic       legal;
      logic [3:0] alu;
      logic [1:0] imm;
      logic [1:0] mem;
      logic       br;
   } dec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   multicycle_control_unit_if #(.OPCODE_W(OW), .ALU_W(AW)) bus ();

   multicycle_control_unit #(
      .OPCODE_W   (OW),
      .ALU_W      (AW),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   dec_t        tbl [64];
   int unsigned legal_ops [22];

   // Reference model: the remaining state route of the instruction in flight.
   // Empty route means waiting in FETCH; a route headed by 5 means trapped.
   int   route [$];
   dec_t cur;
   int   wait_n;
   bit   mvalid = 1'b0;

   logic [2:0]    s_state;
   logic          s_if_req, s_mem_req, s_mem_we, s_reg_write, s_pc_write, s_illegal, s_branch;
   logic [1:0]    s_imm, s_mem_inst;
   logic [AW-1:0] s_alu;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic build_table();
      int unsigned ops  [22] = '{0, 1, 2, 3, 36, 5, 6, 39, 8, 9, 42, 11, 12, 45, 14, 15, 48, 17, 18,
                                 19, 20, 21};
      int unsigned alus [22] = '{1, 1, 1, 1, 1, 1, 1, 9, 9, 9, 3, 3, 3, 4, 4, 4, 5, 5, 5, 6, 0, 0};
      int unsigned imm3 [6]  = '{0, 5, 8, 11, 14, 17};
      int unsigned imm2 [6]  = '{1, 6, 9, 12, 15, 18};
      int unsigned imm1 [4]  = '{2, 3, 20, 21};
      for (int i = 0; i < 64; i++) tbl[i] = '0;
      for (int i = 0; i < 22; i++) begin
         tbl[ops[i]].legal = 1'b1;
         tbl[ops[i]].alu   = 4'(alus[i]);
         legal_ops[i]      = ops[i];
      end
      for (int i = 0; i < 6; i++) tbl[imm3[i]].imm = 2'b11;
      for (int i = 0; i < 6; i++) tbl[imm2[i]].imm = 2'b10;
      for (int i = 0; i < 4; i++) tbl[imm1[i]].imm = 2'b01;
      tbl[2].mem  = 2'b10;
      tbl[3].mem  = 2'b01;
      tbl[20].br  = 1'b1;
      tbl[21].br  = 1'b1;
   endtask

   function automatic dec_t lookup(input logic [OW-1:0] op);
      dec_t d = '0;
      if ((op >> 6) == 0 && tbl[op[5:0]].legal) d = tbl[op[5:0]];
      return d;
   endfunction

   function automatic int exp_state();
      return (route.size() == 0) ? 0 : route[0];
   endfunction

   task automatic bump_wait();
      wait_n++;
`ifdef MCU_TIMEOUT_EN
      if (wait_n == TO) begin
         route  = '{5};
         wait_n = 0;
      end
`endif
   endtask

   task automatic model_step(input logic r, input logic ia, input logic [OW-1:0] op,
                             input logic ma);
      int   st;
      dec_t d;
      if (!r) begin
         route.delete();
         cur    = '0;
         wait_n = 0;
         mvalid = 1'b1;
         return;
      end
      if (!mvalid) return;
      st = exp_state();
      if (st == 5) return;
      if (st == 0) begin
         if (ia) begin
            d      = lookup(op);
            cur    = d;
            wait_n = 0;
            if (!d.legal)           route = '{1, 5};
            else if (d.br)          route = '{1, 2};
            else if (d.mem == 2'b10) route = '{1, 2, 3, 4};
            else if (d.mem == 2'b01) route = '{1, 2, 3};
            else                    route = '{1, 2, 4};
         end else begin
            bump_wait();
         end
      end else if (st == 3) begin
         if (ma) begin
            void'(route.pop_front());
            wait_n = 0;
         end else begin
            bump_wait();
         end
      end else begin
         void'(route.pop_front());
         wait_n = 0;
      end
   endtask

   task automatic compare_model(input logic ma);
      int st;
      st = exp_state();
      chk("state", 32'(s_state), 32'(st));
      chk("if_req", 32'(s_if_req), 32'(st == 0));
      chk("mem_req", 32'(s_mem_req), 32'(st == 3));
      chk("mem_we", 32'(s_mem_we), 32'(st == 3 && cur.mem == 2'b01));
      chk("reg_write", 32'(s_reg_write), 32'(st == 4));
      chk("pc_write", 32'(s_pc_write),
          32'(st == 4 || (st == 2 && cur.br) || (st == 3 && cur.mem == 2'b01 && ma)));
      chk("illegal", 32'(s_illegal), 32'(st == 5));
      chk("branch", 32'(s_branch), 32'(cur.br));
      chk("immediate", 32'(s_imm), 32'(cur.imm));
      chk("mem_inst", 32'(s_mem_inst), 32'(cur.mem));
      chk("alu_control", 32'(s_alu), 32'(cur.alu));
      chk("req_exclusive", 32'(s_if_req && s_mem_req), 32'(0));
   endtask

   task automatic run_cycle(input logic r, input logic ia, input logic [OW-1:0] op,
                            input logic ma);
      @(negedge clk);
      rst_n       = r;
      bus.if_ack  = ia;
      bus.opcode  = op;
      bus.mem_ack = ma;
      #1;
      s_state     = bus.state;
      s_if_req    = bus.if_req;
      s_mem_req   = bus.mem_req;
      s_mem_we    = bus.mem_we;
      s_reg_write = bus.reg_write;
      s_pc_write  = bus.pc_write;
      s_illegal   = bus.illegal;
      s_branch    = bus.branch;
      s_imm       = bus.immediate;
      s_mem_inst  = bus.mem_inst;
      s_alu       = bus.alu_control;
      if (mvalid) compare_model(ma);
      @(posedge clk);
      model_step(r, ia, op, ma);
   endtask

   initial begin
      int            mem_cnt;
      int            exp_to;
      logic          r, ia, ma;
      logic [OW-1:0] op;
      int unsigned   sel;

      build_table();
      rst_n       = 1'b0;
      bus.if_ack  = 1'b0;
      bus.opcode  = '0;
      bus.mem_ack = 1'b0;

      // Reset with stray acks present.
      run_cycle(1'b0, 1'b0, 8'h00, 1'b0);
      run_cycle(1'b0, 1'b1, 8'h00, 1'b1);

      // ALU op 000000, immediate fetch ack: 0,1,2,4,0.
      run_cycle(1'b1, 1'b1, 8'h00, 1'b0);
      chk("rst_state", 32'(s_state), 32'd0);
      chk("rst_if_req", 32'(s_if_req), 32'd1);
      chk("rst_alu", 32'(s_alu), 32'd0);
      chk("rst_illegal", 32'(s_illegal), 32'd0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("alu_decode_state", 32'(s_state), 32'd1);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("alu_exec_state", 32'(s_state), 32'd2);
      chk("alu_exec_rw", 32'(s_reg_write), 32'd0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("alu_wb_state", 32'(s_state), 32'd4);
      chk("alu_wb_rw", 32'(s_reg_write), 32'd1);
      chk("alu_ctl", 32'(s_alu), 32'h1);
      chk("alu_imm", 32'(s_imm), 32'h3);

      // Load 000010 with mem_ack on third MEM cycle.
      run_cycle(1'b1, 1'b1, 8'h02, 1'b0);
      chk("ld_fetch_state", 32'(s_state), 32'd0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b1);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      mem_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b1, 1'b0, 8'h00, (i == 2));
         if (s_mem_req) mem_cnt++;
         chk("ld_mem_we", 32'(s_mem_we), 32'd0);
      end
      chk("ld_mem_cycles", 32'(mem_cnt), 32'd3);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("ld_wb_state", 32'(s_state), 32'd4);
      chk("ld_wb_rw", 32'(s_reg_write), 32'd1);
      chk("ld_mem_inst", 32'(s_mem_inst), 32'h2);

      // Store 000011, ack on first MEM cycle.
      run_cycle(1'b1, 1'b1, 8'h03, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("st_mem_state", 32'(s_state), 32'd3);
      chk("st_mem_we", 32'(s_mem_we), 32'd1);
      chk("st_pc_write", 32'(s_pc_write), 32'd1);
      chk("st_reg_write", 32'(s_reg_write), 32'd0);
      chk("st_mem_inst", 32'(s_mem_inst), 32'h1);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("st_back_fetch", 32'(s_state), 32'd0);

      // Branch 010100: pc_write in EXEC, back to FETCH.
      run_cycle(1'b1, 1'b1, 8'h14, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("br_exec_state", 32'(s_state), 32'd2);
      chk("br_pc_write", 32'(s_pc_write), 32'd1);
      chk("br_alu", 32'(s_alu), 32'h0);
      chk("br_imm", 32'(s_imm), 32'h1);
      chk("br_branch", 32'(s_branch), 32'd1);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("br_back_fetch", 32'(s_state), 32'd0);

      // Illegal 111111: trap held through acks until reset.
      run_cycle(1'b1, 1'b1, 8'h3f, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) begin
         run_cycle(1'b1, 1'($urandom_range(0, 1)), OW'($urandom_range(0, 63)),
                   1'($urandom_range(0, 1)));
         chk("trap_illegal", 32'(s_illegal), 32'd1);
         chk("trap_state", 32'(s_state), 32'd5);
         chk("trap_reqs", 32'({s_if_req, s_mem_req, s_reg_write, s_pc_write}), 32'd0);
      end
      run_cycle(1'b0, 1'b1, 8'h00, 1'b1);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("trap_rst_state", 32'(s_state), 32'd0);
      chk("trap_rst_illegal", 32'(s_illegal), 32'd0);

      // Nonzero bit above [5:0] is illegal even if the low bits decode.
      run_cycle(1'b1, 1'b1, 8'h42, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("hi_bit_trap", 32'(s_state), 32'd5);
      run_cycle(1'b0, 1'b0, 8'h00, 1'b0);

      // Reset during MEM with a simultaneous mem_ack abandons the load.
      run_cycle(1'b1, 1'b1, 8'h02, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      run_cycle(1'b0, 1'b0, 8'h00, 1'b1);
      chk("rst_mem_before", 32'(s_state), 32'd3);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("rst_mem_state", 32'(s_state), 32'd0);
      chk("rst_mem_req", 32'(s_mem_req), 32'd0);
      chk("rst_mem_rw", 32'(s_reg_write), 32'd0);

      // mem_ack never arrives.
      run_cycle(1'b1, 1'b1, 8'h02, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 100; k++) begin
         run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
         exp_to = 3;
`ifdef MCU_TIMEOUT_EN
         if (k >= int'(TO)) exp_to = 5;
`endif
         chk("mem_wait_state", 32'(s_state), 32'(exp_to));
      end
      run_cycle(1'b0, 1'b0, 8'h00, 1'b0);

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         r = ($urandom_range(0, 63) != 0);
         if (exp_state() == 5 && $urandom_range(0, 7) == 0) r = 1'b0;
         ia  = 1'($urandom_range(0, 1));
         ma  = ($urandom_range(0, 4) < 2);
         sel = $urandom_range(0, 19);
         if (sel < 17)      op = OW'(legal_ops[$urandom_range(0, 21)]);
         else if (sel < 19) op = OW'($urandom_range(0, 63));
         else               op = OW'($urandom_range(64, 255));
         run_cycle(r, ia, op, ma);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
